// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
// Optional periodic-reload mode is selected with DOWN_TIMER_RELOAD_EN.
package down_timer_pkg;

  // Controller states: IDLE after clear or a zero load, RUN while counting,
  // DONE once a one-shot count has expired.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_timer_cell.sv
// One bit of the ripple down-counter: loads a bit, toggles on borrow-in,
// and passes a borrow upward when it toggles from 0 to 1.
module down_timer_cell (
  input  logic clk,
  input  logic clr,
  input  logic ld,
  input  logic d,
  input  logic bin,
  output logic q,
  output logic bout
);

  logic bit_q;
  logic bit_d;

  // Next bit value: a load beats a toggle, otherwise hold.
  always_comb begin
    bit_d = bit_q;
    if (ld) begin
      bit_d = d;
    end else if (bin) begin
      bit_d = ~bit_q;
    end
  end

  // Bit register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q    = bit_q;
  // A 0 bit that decrements becomes 1 and borrows from the next bit up.
  assign bout = bin & ~bit_q;

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter/timer with terminal-count pulse and BORROW cascade.
// Define DOWN_TIMER_RELOAD_EN for periodic mode: at the terminal edge the
// counter reloads the last LOAD value instead of stopping at zero.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY,
  output logic             BORROW
);

  state_e             state_q;
  state_e             state_d;
  logic               tc_q;
  logic               tc_d;
  logic               cell_ld;
  logic [WIDTH-1:0]   cell_val;
  logic               dec_en;
  logic [WIDTH:0]     borrow_chain;
  logic [WIDTH-1:0]   count;
  logic               at_one;

`ifdef DOWN_TIMER_RELOAD_EN
  logic [WIDTH-1:0]   reload_q;
  logic [WIDTH-1:0]   reload_d;
`endif

  assign at_one = (count == WIDTH'(1));

  // Next-state, load and decrement control; LOAD outranks the count enable.
  always_comb begin
    state_d  = state_q;
    tc_d     = 1'b0;
    cell_ld  = 1'b0;
    cell_val = D;
    dec_en   = 1'b0;
`ifdef DOWN_TIMER_RELOAD_EN
    reload_d = reload_q;
`endif
    if (LOAD) begin
      cell_ld  = 1'b1;
      cell_val = D;
`ifdef DOWN_TIMER_RELOAD_EN
      reload_d = D;
`endif
      // A zero load has nothing to count, so no terminal pulse follows.
      state_d  = (D != '0) ? RUN : IDLE;
    end else if (state_q == RUN && EN) begin
      if (at_one) begin
        tc_d = 1'b1;
`ifdef DOWN_TIMER_RELOAD_EN
        cell_ld  = 1'b1;
        cell_val = reload_q;
        state_d  = RUN;
`else
        dec_en   = 1'b1;
        state_d  = DONE;
`endif
      end else begin
        dec_en = 1'b1;
      end
    end
  end

  // Controller registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= IDLE;
      tc_q     <= 1'b0;
`ifdef DOWN_TIMER_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tc_q     <= tc_d;
`ifdef DOWN_TIMER_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  // Ripple borrow chain: bit 0 decrements whenever the controller enables it.
  assign borrow_chain[0] = dec_en;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      down_timer_cell u_cell (
        .clk  (CLK),
        .clr  (CLR),
        .ld   (cell_ld),
        .d    (cell_val[gi]),
        .bin  (borrow_chain[gi]),
        .q    (count[gi]),
        .bout (borrow_chain[gi+1])
      );
    end
  endgenerate

  // The top borrow would only fire on a decrement from zero, which the
  // controller never issues.
  logic unused_top_borrow;
  assign unused_top_borrow = borrow_chain[WIDTH];

  assign Q      = count;
  assign TC     = tc_q;
  assign BUSY   = (state_q == RUN);
  assign BORROW = EN & (state_q == RUN) & at_one;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer (WIDTH=4): directed scenarios followed
// by random stimulus, all compared against a cycle-level reference model.
module tb_down_timer;

  localparam int WIDTH = 4;

  logic             CLK;
  logic             CLR;
  logic             EN;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             BUSY;
  logic             BORROW;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining count, whether a count is in progress,
  // pending terminal pulse, and remembered start value.
  int m_cnt;
  bit m_run;
  bit m_tc;
  int m_reload;

  down_timer #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .EN     (EN),
    .LOAD   (LOAD),
    .D      (D),
    .Q      (Q),
    .TC     (TC),
    .BUSY   (BUSY),
    .BORROW (BORROW)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the timer's rules.
  task automatic model_edge(input bit c, input bit l, input bit e, input int dv);
    if (c) begin
      m_cnt = 0; m_run = 0; m_tc = 0; m_reload = 0;
    end else if (l) begin
      m_cnt = dv; m_reload = dv; m_tc = 0; m_run = (dv != 0);
    end else if (m_run && e) begin
      if (m_cnt == 1) begin
        m_tc = 1;
`ifdef DOWN_TIMER_RELOAD_EN
        m_cnt = m_reload;
`else
        m_cnt = 0;
        m_run = 0;
`endif
      end else begin
        m_cnt = m_cnt - 1;
        m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  // One transaction: apply inputs, check BORROW mid-cycle, clock, check state.
  task automatic cycle(input bit c, input bit l, input bit e, input int dv);
    CLR  = c;
    LOAD = l;
    EN   = e;
    D    = dv[WIDTH-1:0];
    @(negedge CLK);
    chk("borrow", int'(BORROW), int'(e && m_run && m_cnt == 1));
    @(posedge CLK);
    model_edge(c, l, e, dv);
    #1;
    chk("q", int'(Q), m_cnt);
    chk("tc", int'(TC), int'(m_tc));
    chk("busy", int'(BUSY), int'(m_run));
    $display("clr=%0b load=%0b en=%0b d=%0d -> q=%0d tc=%0b busy=%0b", c, l, e, dv, Q, TC, BUSY);
  endtask

  initial begin
    int tc_seen;
    CLR = 1'b1; LOAD = 1'b0; EN = 1'b0; D = '0;
    m_cnt = 0; m_run = 0; m_tc = 0; m_reload = 0;
    @(posedge CLK);
    #1;
    chk("reset_q", int'(Q), 0);
    chk("reset_tc", int'(TC), 0);
    chk("reset_busy", int'(BUSY), 0);

    // Clear in the middle of a count, then EN must do nothing.
    cycle(0, 1, 0, 8);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    chk("pre_clear_q", int'(Q), 5);
    cycle(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    chk("post_clear_q", int'(Q), 0);

    // Load 3 with EN held high, then let it sit at its end state.
    cycle(0, 1, 0, 3);
    tc_seen = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 1, 0);
      if (TC) tc_seen++;
    end
`ifdef DOWN_TIMER_RELOAD_EN
    chk("periodic_tc_count", tc_seen, 3);
`else
    chk("oneshot_tc_count", tc_seen, 1);
`endif

    // Load 4 with EN alternating.
    cycle(0, 1, 0, 4);
    for (int i = 0; i < 10; i++) cycle(0, 0, (i % 2) == 0, 0);

    // Zero load, then full-scale load of 15.
    cycle(0, 1, 1, 0);
    chk("zero_load_busy", int'(BUSY), 0);
    cycle(0, 1, 0, 15);
    tc_seen = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, 1, 0);
      if (TC) tc_seen++;
    end
    chk("load15_tc_at_end", tc_seen, 1);

    // LOAD colliding with the terminal condition.
    cycle(0, 1, 0, 2);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 6);
    chk("collide_q", int'(Q), 6);
    chk("collide_tc", int'(TC), 0);

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      bit rc;
      bit rl;
      bit re;
      rc = ($urandom_range(0, 99) < 3);
      rl = ($urandom_range(0, 99) < 12);
      re = ($urandom_range(0, 99) < 70);
      cycle(rc, rl, re, int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable synchronous down-counter/timer: the count-down counterpart to the team's T-flop up-counter.
- Software or board switches load a start value; the block decrements on each enabled cycle.
- Signals terminal count and parks at zero.
- Sits between board switches/KEY clock and LEDR; cascadable through BORROW.

Parameters:
- WIDTH, 4, counter width in bits (2..16).

Ports:
- CLK     input   1      rising-edge clock
- CLR     input   1      synchronous, active-high reset/clear
- EN      input   1      count enable; one decrement per CLK edge while high
- LOAD    input   1      load D into counter on next edge
- D       input   WIDTH  load value
- Q       output  WIDTH  current count
- TC      output  1      registered terminal-count pulse, exactly one cycle
- BUSY    output  1      high while state is RUN
- BORROW  output  1      combinational: EN & (state==RUN) & (Q==1); next edge ends the count

Behaviour:
- Reset (CLR high at an edge):
  - Q=0, TC=0, BUSY=0, state IDLE.
  - Stored reload value = 0.
  - Overrides LOAD and EN; applies mid-count too.
- Priority per edge: CLR > LOAD > EN.
- States: IDLE, RUN, DONE (encoded 2 bits).
- LOAD (any state):
  - Q<=D; reload register <=D; TC<=0.
  - Next state is RUN if D!=0, else IDLE (no TC for a zero load).
- RUN, EN=1, Q>1: Q<=Q-1, stay RUN.
- RUN, EN=1, Q==1 (terminal):
  - Q<=0, TC<=1 for that one cycle.
  - Next state DONE.
- RUN, EN=0: hold Q, TC<=0.
- IDLE/DONE: Q holds, EN ignored, TC<=0.
  - Only LOAD leaves these states.
  - The counter never wraps below 0.
- Latency:
  - Q updates on the same edge as LOAD/EN.
  - TC is visible in the cycle after the terminal edge, aligned with Q==0.
- BUSY = (state==RUN), decoded from registered state.
- Count length: a load of N yields exactly N enabled cycles to TC.
- Simultaneous LOAD and terminal condition: LOAD wins, and TC is not asserted.
- Width rule: Q decrements modulo 2^WIDTH internally. Q==0 is never decremented, because state leaves RUN first.

Optional Feature:
- Macro: DOWN_TIMER_RELOAD_EN.
- Defined: periodic mode.
  - At the terminal edge, Q<=reload register (not 0), TC<=1, state stays RUN.
  - Period = reload value in enabled cycles; DONE is unreachable.
  - A reload value of 1 gives TC on every enabled cycle.
- Undefined: one-shot behaviour as above; there is no reload register. LOAD writes Q only.

Decomposition:
- Package down_timer_pkg:
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - default WIDTH constant.
- Sub-module down_timer_cell: one-bit down-count cell.
  - Inputs: borrow-in, load bit, CLK, CLR. Outputs: Q bit, borrow-out.
  - Toggles when borrow-in is high; borrow-out = borrow-in & ~Q.
  - Instantiated WIDTH times in a generate chain under the FSM's enable.

Test Plan (WIDTH=4):
- CLR for 1 cycle mid-count at Q=5 -> next cycle Q=0, state IDLE, BUSY=0, TC=0; EN then has no effect.
- LOAD D=3, then EN held high -> Q sequence 3,2,1,0, TC=1 only in the Q=0 cycle, BUSY drops with it; Q stays 0 for 5 more cycles.
- LOAD D=4, EN toggling 1,0,1,0,... -> Q holds on EN=0 cycles; TC after exactly 4 enabled edges; BORROW=1 only in the cycle Q==1 & EN=1.
- LOAD D=0 -> Q=0, IDLE, no TC pulse; LOAD D=15 then EN high -> TC after 15 cycles.
- At Q=1 with EN=1, assert LOAD D=6 -> Q=6, TC stays 0, state RUN.
- With DOWN_TIMER_RELOAD_EN, LOAD D=3, EN high for 9 cycles -> Q 3,2,1,3,2,1,3,2,1; TC pulses at cycles 3, 6 and 9; BUSY stays 1.
